// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS execute stage: forwarding, ALU, branch target, EX/MEM register
//
// Ports:
//   clk, reset_n                 pipeline clock, asynchronous active-low reset
//   rd1E, rd2E, RtE, RdE         operands and candidate destinations from ID/EX
//   signimmE, pcplus4E, validE   immediate, PC+4, slot-valid from ID/EX
//   regwriteE..regdstE           decoded control bits
//   alucontrolE                  ALU operation select
//   forwardAE, forwardBE         forwarding selects from the hazard unit
//   resultW                      writeback result, forwarding source
//   stallM, flushM               EX/MEM hold / bubble control (flush wins)
//   writeregE                    combinational destination register to hazard unit
//   *M outputs                   registered EX/MEM contents
module execute_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rd1E,
    input  logic [31:0] rd2E,
    input  logic [4:0]  RtE,
    input  logic [4:0]  RdE,
    input  logic [31:0] signimmE,
    input  logic [31:0] pcplus4E,
    input  logic        validE,
    input  logic        regwriteE,
    input  logic        memtoregE,
    input  logic        memwriteE,
    input  logic        branchE,
    input  logic        alusrcE,
    input  logic        regdstE,
    input  logic [2:0]  alucontrolE,
    input  logic [1:0]  forwardAE,
    input  logic [1:0]  forwardBE,
    input  logic [31:0] resultW,
    input  logic        stallM,
    input  logic        flushM,
    output logic [4:0]  writeregE,
    output logic [31:0] aluoutM,
    output logic [31:0] writedataM,
    output logic [31:0] pcbranchM,
    output logic [4:0]  writeregM,
    output logic        zeroM,
    output logic        validM,
    output logic        regwriteM,
    output logic        memtoregM,
    output logic        memwriteM,
    output logic        branchM
);

    logic [31:0] srca;
    logic [31:0] fwd_b;
    logic [31:0] srcb;
    logic [31:0] alu_result;
    logic [31:0] pcbranch;

    // Forwarding select 10 takes aluoutM as it stands before the edge,
    // i.e. the result of the instruction now in MEM.
    always_comb begin
        case (forwardAE)
            2'b01:   srca = resultW;
            2'b10:   srca = aluoutM;
            default: srca = rd1E;
        endcase
        case (forwardBE)
            2'b01:   fwd_b = resultW;
            2'b10:   fwd_b = aluoutM;
            default: fwd_b = rd2E;
        endcase
    end

    // Store data is always the forwarded B operand, never the immediate.
    assign srcb = alusrcE ? signimmE : fwd_b;

    always_comb begin
        case (alucontrolE)
            3'b000:  alu_result = srca & srcb;
            3'b001:  alu_result = srca | srcb;
            3'b010:  alu_result = srca + srcb;
            3'b110:  alu_result = srca - srcb;
            // True signed compare; the sign of A-B is wrong on overflow.
            3'b111:  alu_result = {31'd0, $signed(srca) < $signed(srcb)};
            3'b100:  alu_result = srca & ~srcb;
            3'b101:  alu_result = srca | ~srcb;
            default: alu_result = 32'd0;
        endcase
    end

    assign writeregE = regdstE ? RdE : RtE;
    assign pcbranch  = pcplus4E + {signimmE[29:0], 2'b00};

    // Flush beats stall: a flushed slot becomes a bubble even while held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aluoutM    <= 32'd0;
            writedataM <= 32'd0;
            pcbranchM  <= 32'd0;
            writeregM  <= 5'd0;
            zeroM      <= 1'b0;
            validM     <= 1'b0;
            regwriteM  <= 1'b0;
            memtoregM  <= 1'b0;
            memwriteM  <= 1'b0;
            branchM    <= 1'b0;
        end else if (flushM) begin
            aluoutM    <= 32'd0;
            writedataM <= 32'd0;
            pcbranchM  <= 32'd0;
            writeregM  <= 5'd0;
            zeroM      <= 1'b0;
            validM     <= 1'b0;
            regwriteM  <= 1'b0;
            memtoregM  <= 1'b0;
            memwriteM  <= 1'b0;
            branchM    <= 1'b0;
        end else if (!stallM) begin
            aluoutM    <= alu_result;
            writedataM <= fwd_b;
            pcbranchM  <= pcbranch;
            writeregM  <= writeregE;
            zeroM      <= (alu_result == 32'd0);
            validM     <= validE;
            regwriteM  <= regwriteE;
            memtoregM  <= memtoregE;
            memwriteM  <= memwriteE;
            branchM    <= branchE;
        end
    end

endmodule
